ro_mem_burst_responder: RTL

- Responder end of the read-only burst memory interface used by the instruction cache linefill path. Signals on that interface: request, addr, rlen, ack, rvalid, rdata.
- Accepts one burst request at a time and acknowledges it. Reads rlen+1 consecutive words from a local synchronous SRAM port. Streams them back in order with rvalid.
- Sits between the L1 arbiter and an on-chip instruction/boot SRAM. Lets the cache be exercised and deployed without an external bus.

---
 rtl/ro_mem_burst_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ro_mem_burst_responder.sv
// Read-only burst responder: acks one aligned burst, reads rlen+1 words from a synchronous SRAM, streams them back.
// Optional performance counters are built when RO_MEM_RESP_PERF_EN is defined.
module ro_mem_burst_responder #(
  parameter int MEM_ADDR_W   = 14,
  parameter int READ_LATENCY = 1,
  parameter int MAX_RLEN_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  request,
  input  logic [29:0]           addr,
  input  logic [MAX_RLEN_W-1:0] rlen,
  output logic                  ack,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  sram_en,
  output logic [MEM_ADDR_W-1:0] sram_addr,
  input  logic [31:0]           sram_rdata,
  output logic                  busy,
  output logic [31:0]           perf_bursts,
  output logic [31:0]           perf_words
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_next;
  logic [29:0]             base, rlen_ext, word_addr;
  logic [MAX_RLEN_W-1:0]   len, issue_cnt;
  logic [READ_LATENCY-1:0] vpipe, vpipe_older;
  logic                    pending;
  logic                    unused_addr_hi;

  assign rlen_ext       = {{(30-MAX_RLEN_W){1'b0}}, rlen};
  assign word_addr      = base + {{(30-MAX_RLEN_W){1'b0}}, issue_cnt};
  assign sram_addr      = word_addr[MEM_ADDR_W-1:0];
  assign unused_addr_hi = ^word_addr[29:MEM_ADDR_W];

  // Reads still in flight other than the one being presented this cycle.
  always_comb begin
    vpipe_older                 = vpipe;
    vpipe_older[READ_LATENCY-1] = 1'b0;
  end
  assign pending = |vpipe_older;

  // The SRAM output register is the data stage; rvalid is the registered pipeline tail.
  assign rvalid = vpipe[READ_LATENCY-1];
  assign rdata  = rvalid ? sram_rdata : 32'h0;
  assign busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    ack        = 1'b0;
    sram_en    = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          ack        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        sram_en = 1'b1;
        if (issue_cnt == len) state_next = DRAIN;
      end
      DRAIN: begin
        if (!pending) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      issue_cnt <= '0;
      vpipe     <= '0;
    end else begin
      state <= state_next;
      if (ack) begin
        base      <= addr & ~rlen_ext;
        len       <= rlen;
        issue_cnt <= '0;
      end else if (sram_en) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      vpipe[0] <= sram_en;
      for (int i = 1; i < READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

`ifdef RO_MEM_RESP_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bursts <= '0;
      perf_words  <= '0;
    end else begin
      if (ack)    perf_bursts <= perf_bursts + 32'd1;
      if (rvalid) perf_words  <= perf_words + 32'd1;
    end
  end
`else
  assign perf_bursts = '0;
  assign perf_words  = '0;
`endif

`ifndef SYNTHESIS
  logic [MAX_RLEN_W:0] rv_cnt, rv_total, burst_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rv_cnt <= '0;
    else if (ack)    rv_cnt <= '0;
    else if (rvalid) rv_cnt <= rv_cnt + 1'b1;
  end

  assign rv_total    = rv_cnt + {{MAX_RLEN_W{1'b0}}, rvalid};
  assign burst_words = {1'b0, len} + 1'b1;

  a_no_ack_busy: assert property (@(posedge clk) disable iff (!rst_n) ack |-> !busy);
  a_rlen_pow2:   assert property (@(posedge clk) disable iff (!rst_n) ack |-> ((rlen & (rlen + 1'b1)) == '0));
  a_word_count:  assert property (@(posedge clk) disable iff (!rst_n)
                   (state == DRAIN && state_next == IDLE) |-> (rv_total == burst_words));
  a_req_held:    assert property (@(posedge clk) disable iff (!rst_n) (request && !ack) |=> request);
`endif

endmodule
